cell_processor: RTL and testbench
=================================

Name: cell_processor

Overview:
- Single-stage image-cell arithmetic core: takes one instruction word carrying an opcode and two square pixel cells (A, B), and produces one registered RGB result pixel per clock.
- Sits inside the image processor datapath. An upstream sequencer presents one instruction per cycle. The result feeds the output/writeback stage.
- Pixels are 24-bit RGB, {R[23:16], G[15:8], B[7:0]}. Channel arithmetic is unsigned 8-bit and saturating.

Parameters:
- CELL_DIM, 3, side length of the square cell (odd, ≥3). Center index is CENTER = CELL_DIM/2 (integer division).
- PIXEL_W, 24, pixel width, fixed at three 8-bit channels.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. Asserting (0) clears state immediately; deassertion is synchronized to clk by the integrator.
- IW  input  3+2*CELL_DIM*CELL_DIM*24 (435 at default)  instruction word, layout below.
- result  output  24  registered result pixel.

Behaviour:
- IW layout, MSB→LSB: opcode[2:0], cellA, cellB.
- Each cell is CELL_DIM×CELL_DIM pixels. Pixel (i,j), row i, column j, sits at offset ((i*CELL_DIM)+j)*24 from the cell LSB, i.e. (0,0) is the lowest pixel.
- Ac = cellA(CENTER,CENTER); Bc = cellB(CENTER,CENTER).
- Opcodes; every operation is applied per channel (R, G, B independently):
  - 0 ADD: min(Ac+Bc, 255).
  - 1 SUB: max(Ac−Bc, 0).
  - 2 AVG: floor((Ac+Bc)/2).
  - 3 MAX: max(Ac, Bc).
  - 4 MIN: min(Ac, Bc).
  - 5 BLURA: floor(sum of all CELL_DIM² cellA pixels / CELL_DIM²). Box mean; the accumulator must be wide enough not to overflow (8+ceil(log2(CELL_DIM²)) bits).
  - 6 BLURB: same as BLURA, applied to cellB.
  - 7 NOP: result holds its previous value.
- Latency: exactly 1 cycle. IW is sampled on a rising clk edge, and result updates at that same edge. Combinational compute from IW to result register; no handshake, no valid signal. A new instruction is accepted every cycle.
- IW changes between edges have no effect until the next edge.
- Reset: while rst=0, result=24'h000000, regardless of clk or IW. Reset asserted mid-stream discards the in-flight computation.
- First edge after rst returns to 1: result reflects the IW present at that edge.
- Boundaries:
  - Saturation is per channel and never wraps. FF+01 → FF; 00−01 → 00.
  - AVG: FF+FF → FF, 01+00 → 00 (floor).
  - BLUR of a uniform cell returns that color exactly.
  - Unknown/X opcode bits are not legal. The implementation treats any value not listed as NOP. With 3 bits all codes are defined.
- No internal state besides the result register.

Test Plan:
- Reset: rst=0 with cellA=cellB=all blue (0000FF), opcode ADD, for 2 cycles → result=000000 throughout. Release rst → result=0000FF+0000FF saturated = 0000FF one edge later.
- ADD color sweep, all pixels set uniformly, one edge after each change:
  - A=black, B=black → 000000
  - B=lime → 00FF00
  - A=blue → 00FFFF
  - B=red → FF00FF
- Saturation/clamp:
  - ADD A=FFFFFF, B=010101 → FFFFFF
  - SUB A=102030, B=203010 → 000020
  - AVG A=FFFFFF, B=010101 → 808080
- MAX/MIN: A=FF0080, B=00FF40 → MAX=FFFF80, MIN=000040.
- BLURA, CELL_DIM=3: cellA all black except center=FFFFFF and (0,0)=090909 → per channel floor((255+9)/9)=29 → 1D1D1D. BLURB on uniform red → FF0000.
- NOP and async reset:
  - Issue ADD producing 00FF00, then NOP with different cells → result stays 00FF00.
  - Assert rst mid-cycle between edges → result drops to 000000 before the next clk edge.

Source files
------------

// File: rtl/cell_processor.sv
// Single-stage image-cell arithmetic core.
// Applies a saturating per-channel op to two pixel cells into a registered pixel.
module cell_processor #(
   parameter int CELL_DIM = 3,
   parameter int PIXEL_W  = 24
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [3+2*CELL_DIM*CELL_DIM*PIXEL_W-1:0] IW,
   output logic [PIXEL_W-1:0]                     result
);

   localparam int NPIX   = CELL_DIM * CELL_DIM;
   localparam int CELL_W = NPIX * PIXEL_W;
   localparam int CENTER = CELL_DIM / 2;
   localparam int C_OFF  = ((CENTER * CELL_DIM) + CENTER) * PIXEL_W;
   localparam int NCH    = PIXEL_W / 8;
   localparam int ACC_W  = 8 + $clog2(NPIX);

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AVG   = 3'd2;
   localparam logic [2:0] OP_MAX   = 3'd3;
   localparam logic [2:0] OP_MIN   = 3'd4;
   localparam logic [2:0] OP_BLURA = 3'd5;
   localparam logic [2:0] OP_BLURB = 3'd6;

   logic [2:0]         opcode;
   logic [CELL_W-1:0]  cell_a;
   logic [CELL_W-1:0]  cell_b;
   logic [PIXEL_W-1:0] a_c;
   logic [PIXEL_W-1:0] b_c;
   logic [PIXEL_W-1:0] nxt;
   logic [ACC_W-1:0]   acc_a [NCH];
   logic [ACC_W-1:0]   acc_b [NCH];

   assign opcode = IW[3+2*CELL_W-1 -: 3];
   assign cell_a = IW[2*CELL_W-1 -: CELL_W];
   assign cell_b = IW[CELL_W-1:0];
   assign a_c    = cell_a[C_OFF +: PIXEL_W];
   assign b_c    = cell_b[C_OFF +: PIXEL_W];

   // Box sums sized so a full cell of 0xFF never overflows.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         acc_a[c] = '0;
         acc_b[c] = '0;
         for (int p = 0; p < NPIX; p++) begin
            acc_a[c] = acc_a[c] + ACC_W'(cell_a[p*PIXEL_W + c*8 +: 8]);
            acc_b[c] = acc_b[c] + ACC_W'(cell_b[p*PIXEL_W + c*8 +: 8]);
         end
      end
   end

   function automatic logic [7:0] mean(input logic [ACC_W-1:0] acc);
      mean = 8'(acc / ACC_W'(NPIX));
   endfunction

   function automatic logic [7:0] chan_op(
      input logic [2:0]       op,
      input logic [7:0]       a,
      input logic [7:0]       b,
      input logic [ACC_W-1:0] sa,
      input logic [ACC_W-1:0] sb,
      input logic [7:0]       hold
   );
      logic [8:0] sum;
      logic [8:0] dif;
      sum = {1'b0, a} + {1'b0, b};
      dif = {1'b0, a} - {1'b0, b};
      case (op)
         OP_ADD:   chan_op = sum[8] ? 8'hFF : sum[7:0];
         OP_SUB:   chan_op = dif[8] ? 8'h00 : dif[7:0];
         OP_AVG:   chan_op = sum[8:1];
         OP_MAX:   chan_op = (a > b) ? a : b;
         OP_MIN:   chan_op = (a < b) ? a : b;
         OP_BLURA: chan_op = mean(sa);
         OP_BLURB: chan_op = mean(sb);
         default:  chan_op = hold;
      endcase
   endfunction

   always_comb begin
      nxt = result;
      for (int c = 0; c < NCH; c++) begin
         nxt[c*8 +: 8] = chan_op(opcode, a_c[c*8 +: 8], b_c[c*8 +: 8],
                                 acc_a[c], acc_b[c], result[c*8 +: 8]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result <= '0;
      end else begin
         result <= nxt;
      end
   end

endmodule

// File: tb/tb_cell_processor.sv
// Directed self-checking bench for cell_processor.
// Hand-computed vectors with immediate assertions at each check point.
module tb_cell_processor;

   localparam int CD   = 3;
   localparam int NP   = CD * CD;
   localparam int CW   = NP * 24;
   localparam int IWW  = 3 + 2 * CW;

   localparam logic [2:0] ADD   = 3'd0;
   localparam logic [2:0] SUB   = 3'd1;
   localparam logic [2:0] AVG   = 3'd2;
   localparam logic [2:0] MAX   = 3'd3;
   localparam logic [2:0] MIN   = 3'd4;
   localparam logic [2:0] BLURA = 3'd5;
   localparam logic [2:0] BLURB = 3'd6;
   localparam logic [2:0] NOP   = 3'd7;

   logic            clk = 1'b0;
   logic            rst;
   logic [IWW-1:0]  iw;
   logic [23:0]     result;
   logic [CW-1:0]   ca;
   int              vectors = 0;
   int              miscompares = 0;

   always #5 clk = ~clk;

   cell_processor #(.CELL_DIM(CD), .PIXEL_W(24)) dut (
      .clk    (clk),
      .rst    (rst),
      .IW     (iw),
      .result (result)
   );

   function automatic logic [CW-1:0] fill(input logic [23:0] c);
      logic [CW-1:0] f;
      for (int i = 0; i < NP; i++) f[i*24 +: 24] = c;
      return f;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [CW-1:0] a,
                        input logic [CW-1:0] b);
      iw = {op, a, b};
   endtask

   task automatic check(input string tag, input logic [23:0] exp);
      vectors++;
      assert (result === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, result, exp);
      end
   endtask

   task automatic step(input string tag, input logic [23:0] exp);
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      rst = 1'b1;
      drive(ADD, fill(24'h0000FF), fill(24'h0000FF));
      #2 rst = 1'b0;
      #1 check("rst_async", 24'h000000);
      step("rst_hold1", 24'h000000);
      step("rst_hold2", 24'h000000);
      #3 rst = 1'b1;
      step("rst_release", 24'h0000FF);

      drive(ADD, fill(24'h000000), fill(24'h000000));
      step("add_black", 24'h000000);
      drive(ADD, fill(24'h000000), fill(24'h00FF00));
      step("add_lime", 24'h00FF00);
      drive(ADD, fill(24'h0000FF), fill(24'h00FF00));
      step("add_blue", 24'h00FFFF);
      drive(ADD, fill(24'h0000FF), fill(24'hFF0000));
      step("add_red", 24'hFF00FF);

      // Input change between edges must not reach the output early.
      drive(ADD, fill(24'h123456), fill(24'h000000));
      #2 check("iw_between", 24'hFF00FF);

      drive(ADD, fill(24'hFFFFFF), fill(24'h010101));
      step("add_sat", 24'hFFFFFF);
      drive(SUB, fill(24'h102030), fill(24'h203010));
      step("sub_clamp", 24'h000020);
      drive(SUB, fill(24'h000000), fill(24'h010101));
      step("sub_zero", 24'h000000);
      drive(AVG, fill(24'hFFFFFF), fill(24'h010101));
      step("avg_hi", 24'h808080);
      drive(AVG, fill(24'hFFFFFF), fill(24'hFFFFFF));
      step("avg_ff", 24'hFFFFFF);
      drive(AVG, fill(24'h010101), fill(24'h000000));
      step("avg_floor", 24'h000000);

      drive(MAX, fill(24'hFF0080), fill(24'h00FF40));
      step("max", 24'hFFFF80);
      drive(MIN, fill(24'hFF0080), fill(24'h00FF40));
      step("min", 24'h000040);

      ca = fill(24'h000000);
      ca[4*24 +: 24] = 24'hFFFFFF;
      ca[0 +: 24]    = 24'h090909;
      drive(BLURA, ca, fill(24'h00FF00));
      step("blura", 24'h1D1D1D);
      drive(BLURB, ca, fill(24'hFF0000));
      step("blurb_red", 24'hFF0000);
      drive(BLURB, fill(24'hFF0000), ca);
      step("blurb_mix", 24'h1D1D1D);

      drive(ADD, fill(24'h00FF00), fill(24'h000000));
      step("nop_pre", 24'h00FF00);
      drive(NOP, fill(24'hFFFFFF), fill(24'h0A0B0C));
      step("nop_hold", 24'h00FF00);

      #2 rst = 1'b0;
      #1 check("rst_mid", 24'h000000);
      step("rst_mid_hold", 24'h000000);
      drive(MAX, fill(24'h112233), fill(24'h332211));
      #3 rst = 1'b1;
      step("rst_mid_release", 24'h332233);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
